// File: rtl/regfile_2w2r_sb_pkg.sv
// Shared defaults and helpers for the 2-write/2-read register file.
// Holds width defaults, the depth derivation and the read-source encoding.
package regfile_2w2r_sb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  // Which value a read port forwards this cycle.
  typedef enum logic [1:0] {
    SRC_ARR,
    SRC_ALU,
    SRC_LD
  } rd_src_e;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one pending-load bit per register plus sticky error.
// Ports: issue (issue_en/issue_rd), load clear (ld_wr_*), two busy reads.
module regfile_scoreboard
  import regfile_2w2r_sb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int R0_ZERO = 0,
  parameter int BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_rd,
  input  logic                  ld_wr_en,
  input  logic [ADDR_W-1:0]     ld_wr_addr,
  input  logic [ADDR_W-1:0]     rs1_addr,
  input  logic [ADDR_W-1:0]     rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [2**ADDR_W-1:0]  busy_vec,
  output logic                  sb_err
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             iss_ok;
  logic             ld_ok;
  logic             err_set;

  // Register 0 is inert when hard-wired to zero.
  assign iss_ok = issue_en &&
    !(R0_ZERO != 0 && issue_rd == '0);
  assign ld_ok = ld_wr_en &&
    !(R0_ZERO != 0 && ld_wr_addr == '0);

  assign err_set = ld_ok && !busy_q[ld_wr_addr];

  // Issue applied after clear: a new load wins.
  always_comb begin
    busy_d = busy_q;
    if (ld_ok)
      busy_d[ld_wr_addr] = 1'b0;
    if (iss_ok)
      busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      sb_err <= 1'b0;
    end else begin
      busy_q <= busy_d;
      sb_err <= sb_err | err_set;
    end
  end

  assign busy_vec = busy_q;

  function automatic logic rd_busy(
    input logic [ADDR_W-1:0] a
  );
    logic b;
    b = busy_q[a];
    if (BYPASS != 0 && ld_wr_en && ld_wr_addr == a)
      b = 1'b0;
    if (reset || (R0_ZERO != 0 && a == '0))
      b = 1'b0;
    return b;
  endfunction

  always_comb begin
    rs1_busy = rd_busy(rs1_addr);
    rs2_busy = rd_busy(rs2_addr);
  end

endmodule

// File: rtl/regfile_2w2r_sb.sv
// Register file, 2 sync write ports (ALU, load) and 2 comb read ports.
// Ports: rs1/rs2 reads, wr_* (ALU), ld_wr_* (load), issue_*, busy_vec, sb_err.
module regfile_2w2r_sb
  import regfile_2w2r_sb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int R0_ZERO = 0,
  parameter int BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     rs1_addr,
  input  logic [ADDR_W-1:0]     rs2_addr,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  reg_wr_en,
  input  logic [ADDR_W-1:0]     ld_wr_addr,
  input  logic [DATA_W-1:0]     ld_wr_data,
  input  logic                  ld_wr_en,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_rd,
  output logic [2**ADDR_W-1:0]  busy_vec,
  output logic                  sb_err
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              a_ok;
  logic              l_ok;

  assign a_ok = reg_wr_en &&
    !(R0_ZERO != 0 && wr_addr == '0);
  assign l_ok = ld_wr_en &&
    !(R0_ZERO != 0 && ld_wr_addr == '0);

  // Port A assigned last so the younger ALU result wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      if (l_ok)
        regs[ld_wr_addr] <= ld_wr_data;
      if (a_ok)
        regs[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_mux(
    input logic [ADDR_W-1:0] a
  );
    rd_src_e           src;
    logic              hit_a;
    logic              hit_l;
    logic [DATA_W-1:0] v;
    hit_a = BYPASS != 0 && reg_wr_en && wr_addr == a;
    hit_l = BYPASS != 0 && ld_wr_en && ld_wr_addr == a
            && !hit_a;
    src = SRC_ARR;
    unique case (1'b1)
      hit_a:   src = SRC_ALU;
      hit_l:   src = SRC_LD;
      default: src = SRC_ARR;
    endcase
    unique case (src)
      SRC_ALU: v = wr_data;
      SRC_LD:  v = ld_wr_data;
      default: v = regs[a];
    endcase
    if (reset || (R0_ZERO != 0 && a == '0))
      v = '0;
    return v;
  endfunction

  always_comb begin
    rs1_data = rd_mux(rs1_addr);
    rs2_data = rd_mux(rs2_addr);
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .ld_wr_en   (ld_wr_en),
    .ld_wr_addr (ld_wr_addr),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .busy_vec   (busy_vec),
    .sb_err     (sb_err)
  );

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Bench for regfile_2w2r_sb: bypass/no-zero and no-bypass/zero-r0 copies.
// Expected values queued with stimulus, drained at the negedge.
module tb_regfile_2w2r_sb;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rs1_addr, rs2_addr;
  logic [1:0] wr_addr, ld_wr_addr, issue_rd;
  logic [7:0] wr_data, ld_wr_data;
  logic       reg_wr_en, ld_wr_en, issue_en;

  logic [7:0] rs1_data, rs2_data;
  logic       rs1_busy, rs2_busy;
  logic [3:0] busy_vec;
  logic       sb_err;

  logic [7:0] z_rs1_data, z_rs2_data;
  logic       z_rs1_busy, z_rs2_busy;
  logic [3:0] z_busy_vec;
  logic       z_sb_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_2w2r_sb dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .reg_wr_en(reg_wr_en),
    .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
    .ld_wr_en(ld_wr_en),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .busy_vec(busy_vec), .sb_err(sb_err)
  );

  regfile_2w2r_sb #(
    .R0_ZERO(1), .BYPASS(0)
  ) dut_z (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(z_rs1_data), .rs2_data(z_rs2_data),
    .rs1_busy(z_rs1_busy), .rs2_busy(z_rs2_busy),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .reg_wr_en(reg_wr_en),
    .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
    .ld_wr_en(ld_wr_en),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .busy_vec(z_busy_vec), .sb_err(z_sb_err)
  );

  typedef enum {
    O_R1D, O_R2D, O_R1B, O_R2B, O_BV, O_ERR,
    Z_R1D, Z_R2D, Z_R1B, Z_R2B, Z_BV, Z_ERR
  } sel_e;

  string      tag_q[$];
  sel_e       sel_q[$];
  logic [7:0] exp_q[$];

  function automatic logic [7:0] obs(input sel_e s);
    case (s)
      O_R1D:   return rs1_data;
      O_R2D:   return rs2_data;
      O_R1B:   return {7'b0, rs1_busy};
      O_R2B:   return {7'b0, rs2_busy};
      O_BV:    return {4'b0, busy_vec};
      O_ERR:   return {7'b0, sb_err};
      Z_R1D:   return z_rs1_data;
      Z_R2D:   return z_rs2_data;
      Z_R1B:   return {7'b0, z_rs1_busy};
      Z_R2B:   return {7'b0, z_rs2_busy};
      Z_BV:    return {4'b0, z_busy_vec};
      default: return {7'b0, z_sb_err};
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic want(input string tag, input sel_e s,
                      input logic [7:0] e);
    tag_q.push_back(tag);
    sel_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk);
    while (sel_q.size() > 0) begin
      string      t;
      sel_e       s;
      logic [7:0] e;
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      chk(t, obs(s), e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_wr_en = 0; ld_wr_en = 0; issue_en = 0;
    wr_addr = 0; wr_data = 0;
    ld_wr_addr = 0; ld_wr_data = 0;
    issue_rd = 0;
  endtask

  initial begin
    reset = 1; rs1_addr = 0; rs2_addr = 0;
    idle();
    want("rst_r1d", O_R1D, 8'h00);
    want("rst_r1b", O_R1B, 8'h00);
    want("rst_zr1d", Z_R1D, 8'h00);
    cyc();
    reset = 0;
    want("post_bv", O_BV, 8'h0);
    want("post_err", O_ERR, 8'h0);
    want("post_zbv", Z_BV, 8'h0);
    want("post_r1d", O_R1D, 8'h00);
    cyc();
    // write AA to r2 via port A
    reg_wr_en = 1; wr_addr = 2; wr_data = 8'hAA;
    rs1_addr = 2;
    want("byp_aa", O_R1D, 8'hAA);
    want("nobyp_aa", Z_R1D, 8'h00);
    cyc(); idle();
    want("rd_aa", O_R1D, 8'hAA);
    want("zrd_aa", Z_R1D, 8'hAA);
    want("bv_aa", O_BV, 8'h0);
    cyc();
    // write AE to r0
    reg_wr_en = 1; wr_addr = 0; wr_data = 8'hAE;
    rs1_addr = 0;
    want("byp_ae", O_R1D, 8'hAE);
    want("nobyp_ae", Z_R1D, 8'h00);
    cyc(); idle();
    want("rd_r0", O_R1D, 8'hAE);
    want("zrd_r0", Z_R1D, 8'h00);
    cyc();
    // issue r1, then dual write to r1
    issue_en = 1; issue_rd = 1;
    cyc(); idle();
    rs2_addr = 1;
    want("r1_busy", O_R2B, 8'h1);
    want("bv_r1", O_BV, 8'h2);
    want("zbv_r1", Z_BV, 8'h2);
    want("zr1_busy", Z_R2B, 8'h1);
    cyc();
    reg_wr_en = 1; wr_addr = 1; wr_data = 8'hCC;
    ld_wr_en = 1; ld_wr_addr = 1; ld_wr_data = 8'h33;
    rs1_addr = 1;
    want("dual_byp", O_R1D, 8'hCC);
    want("dual_bbyp", O_R1B, 8'h0);
    want("dual_zd", Z_R1D, 8'h00);
    want("dual_zb", Z_R1B, 8'h1);
    cyc(); idle();
    want("dual_d", O_R1D, 8'hCC);
    want("dual_zd2", Z_R1D, 8'hCC);
    want("dual_bv", O_BV, 8'h0);
    want("dual_err", O_ERR, 8'h0);
    want("dual_zerr", Z_ERR, 8'h0);
    cyc();
    // issue r3, two idle cycles, then load
    issue_en = 1; issue_rd = 3;
    cyc(); idle();
    rs2_addr = 3;
    want("r3_bv1", O_BV, 8'h8);
    cyc();
    want("r3_busy", O_R2B, 8'h1);
    want("r3_bv2", O_BV, 8'h8);
    want("r3_zbv", Z_BV, 8'h8);
    cyc();
    ld_wr_en = 1; ld_wr_addr = 3; ld_wr_data = 8'h5A;
    want("ld_bbyp", O_R2B, 8'h0);
    want("ld_dbyp", O_R2D, 8'h5A);
    want("ld_zb", Z_R2B, 8'h1);
    want("ld_zd", Z_R2D, 8'h00);
    cyc(); idle();
    want("ld_d", O_R2D, 8'h5A);
    want("ld_zd2", Z_R2D, 8'h5A);
    want("ld_bv", O_BV, 8'h0);
    cyc();
    // issue and clear r2 together while r2 busy
    issue_en = 1; issue_rd = 2;
    cyc(); idle();
    issue_en = 1; issue_rd = 2;
    ld_wr_en = 1; ld_wr_addr = 2; ld_wr_data = 8'h77;
    rs1_addr = 2;
    want("ic_dbyp", O_R1D, 8'h77);
    want("ic_bbyp", O_R1B, 8'h0);
    want("ic_zd", Z_R1D, 8'hAA);
    want("ic_zb", Z_R1B, 8'h1);
    cyc(); idle();
    want("ic_bv", O_BV, 8'h4);
    want("ic_zbv", Z_BV, 8'h4);
    want("ic_b", O_R1B, 8'h1);
    want("ic_d", O_R1D, 8'h77);
    want("ic_err", O_ERR, 8'h0);
    cyc();
    // load to non-busy r1 -> sticky error
    ld_wr_en = 1; ld_wr_addr = 1; ld_wr_data = 8'h11;
    rs1_addr = 1;
    want("err_dbyp", O_R1D, 8'h11);
    want("err_zd", Z_R1D, 8'hCC);
    want("err_pre", O_ERR, 8'h0);
    cyc(); idle();
    want("err_set", O_ERR, 8'h1);
    want("err_zset", Z_ERR, 8'h1);
    cyc();
    want("err_hold", O_ERR, 8'h1);
    want("err_zhold", Z_ERR, 8'h1);
    want("err_d", O_R1D, 8'h11);
    cyc();
    // write FF to r0 and issue r0
    reg_wr_en = 1; wr_addr = 0; wr_data = 8'hFF;
    issue_en = 1; issue_rd = 0;
    rs1_addr = 0;
    want("r0_dbyp", O_R1D, 8'hFF);
    want("r0_zd", Z_R1D, 8'h00);
    want("r0_zb", Z_R1B, 8'h0);
    cyc(); idle();
    want("r0_d", O_R1D, 8'hFF);
    want("r0_b", O_R1B, 8'h1);
    want("r0_bv", O_BV, 8'h5);
    want("r0_zd2", Z_R1D, 8'h00);
    want("r0_zb2", Z_R1B, 8'h0);
    want("r0_zbv", Z_BV, 8'h4);
    cyc();
    // reset during activity
    reset = 1;
    reg_wr_en = 1; wr_addr = 3; wr_data = 8'hEE;
    issue_en = 1; issue_rd = 1;
    ld_wr_en = 1; ld_wr_addr = 2; ld_wr_data = 8'h99;
    rs1_addr = 3; rs2_addr = 1;
    want("mid_r1d", O_R1D, 8'h00);
    want("mid_r1b", O_R1B, 8'h0);
    cyc(); idle();
    reset = 0;
    want("mr_r1d", O_R1D, 8'h00);
    want("mr_r2b", O_R2B, 8'h0);
    want("mr_bv", O_BV, 8'h0);
    want("mr_err", O_ERR, 8'h0);
    want("mr_zbv", Z_BV, 8'h0);
    want("mr_zerr", Z_ERR, 8'h0);
    want("mr_zr1d", Z_R1D, 8'h00);
    cyc();
    // load to r0: error only without zero register
    ld_wr_en = 1; ld_wr_addr = 0; ld_wr_data = 8'h44;
    rs1_addr = 0;
    want("l0_dbyp", O_R1D, 8'h44);
    cyc(); idle();
    want("l0_err", O_ERR, 8'h1);
    want("l0_zerr", Z_ERR, 8'h0);
    want("l0_d", O_R1D, 8'h44);
    want("l0_zd", Z_R1D, 8'h00);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
